// File: rtl/wb_uart_rx.sv
// Wishbone-attached 8N1 UART receiver with a small receive FIFO,
// sticky overrun/framing flags and a maskable receive interrupt.
module wb_uart_rx #(
   parameter int WB_DATA_WIDTH = 32,
   parameter int WB_ADDR_WIDTH = 32,
   parameter int CLKS_PER_BIT  = 16,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [WB_ADDR_WIDTH-1:0]   wb_addr_i,
   input  logic [WB_DATA_WIDTH-1:0]   wb_data_i,
   input  logic [WB_DATA_WIDTH/8-1:0] wb_sel_i,
   input  logic                       wb_we_i,
   input  logic                       wb_cyc_i,
   input  logic                       wb_stb_i,
   output logic                       wb_ack_o,
   output logic [WB_DATA_WIDTH-1:0]   wb_data_o,
   input  logic                       uart_rx_i,
   output logic                       rx_irq_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int TMR_W = $clog2(CLKS_PER_BIT);
   localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state_reg, state_next;
   logic [TMR_W-1:0] timer_reg, timer_next;
   logic [2:0]       bit_idx_reg, bit_idx_next;
   logic [7:0]       shift_reg, shift_next;
   logic             sync1_reg, sync2_reg, rx_prev_reg;
   logic             rx_done, rx_ferr;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             empty, full, push_ok, pop;

   logic             ovr_reg, ovr_next;
   logic             ferr_reg, ferr_next;
   logic             irq_en_reg, irq_en_next;
   logic             ack_reg;
   logic [WB_DATA_WIDTH-1:0] rdata_reg, rdata_next;
   logic             req, wr_status, wr_ctrl;
   logic [1:0]       reg_sel;
   logic             unused_bits;

   assign unused_bits = ^{wb_sel_i, wb_addr_i[WB_ADDR_WIDTH-1:4], wb_addr_i[1:0],
                          wb_data_i[WB_DATA_WIDTH-1:4], wb_data_i[1]};

   // Two-flop synchroniser plus a delayed copy for falling-edge detection
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_reg   <= 1'b1;
         sync2_reg   <= 1'b1;
         rx_prev_reg <= 1'b1;
      end else begin
         sync1_reg   <= uart_rx_i;
         sync2_reg   <= sync1_reg;
         rx_prev_reg <= sync2_reg;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg   <= IDLE;
         timer_reg   <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         timer_reg   <= timer_next;
         bit_idx_reg <= bit_idx_next;
         shift_reg   <= shift_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      timer_next   = timer_reg + 1'b1;
      bit_idx_next = bit_idx_reg;
      shift_next   = shift_reg;
      rx_done      = 1'b0;
      rx_ferr      = 1'b0;
      unique case (state_reg)
         IDLE: begin
            timer_next = '0;
            if (rx_prev_reg && !sync2_reg)
               state_next = START;
         end
         START: begin
            if (timer_reg == HALF_LAST) begin
               timer_next   = '0;
               bit_idx_next = '0;
               state_next   = sync2_reg ? IDLE : DATA;
            end
         end
         DATA: begin
            if (timer_reg == BIT_LAST) begin
               timer_next   = '0;
               shift_next   = {sync2_reg, shift_reg[7:1]};
               bit_idx_next = bit_idx_reg + 3'd1;
               if (bit_idx_reg == 3'd7)
                  state_next = STOP;
            end
         end
         STOP: begin
            if (timer_reg == BIT_LAST) begin
               timer_next = '0;
               state_next = IDLE;
               if (sync2_reg)
                  rx_done = 1'b1;
               else
                  rx_ferr = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign req       = wb_cyc_i & wb_stb_i & ~ack_reg;
   assign reg_sel   = wb_addr_i[3:2];
   assign wr_status = req & wb_we_i & (reg_sel == 2'd1);
   assign wr_ctrl   = req & wb_we_i & (reg_sel == 2'd2);
   assign empty     = (count_reg == '0);
   assign full      = (count_reg == FULL_CNT);
   assign pop       = req & ~wb_we_i & (reg_sel == 2'd0) & ~empty;
   // A full FIFO still accepts a byte when a pop frees a slot in the same cycle
   assign push_ok   = rx_done & (~full | pop);

   always_ff @(posedge clk_i) begin
      if (push_ok)
         mem[wr_ptr_reg] <= shift_reg;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Receiver-side sets win over a simultaneous write-one-to-clear
   always_comb begin
      ovr_next    = ovr_reg;
      ferr_next   = ferr_reg;
      irq_en_next = irq_en_reg;
      if (wr_status && wb_data_i[2])
         ovr_next = 1'b0;
      if (rx_done && full && !pop)
         ovr_next = 1'b1;
      if (wr_status && wb_data_i[3])
         ferr_next = 1'b0;
      if (rx_ferr)
         ferr_next = 1'b1;
      if (wr_ctrl)
         irq_en_next = wb_data_i[0];
   end

   always_comb begin
      rdata_next = '0;
      if (req && !wb_we_i) begin
         case (reg_sel)
            2'd0: begin
               if (!empty) begin
                  rdata_next[31]  = 1'b1;
                  rdata_next[7:0] = mem[rd_ptr_reg];
               end
            end
            2'd1: begin
               rdata_next[0]         = ~empty;
               rdata_next[1]         = full;
               rdata_next[2]         = ovr_reg;
               rdata_next[3]         = ferr_reg;
               rdata_next[8 +: CNT_W] = count_reg;
            end
            2'd2:    rdata_next[0] = irq_en_reg;
            default: rdata_next = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovr_reg    <= 1'b0;
         ferr_reg   <= 1'b0;
         irq_en_reg <= 1'b0;
         ack_reg    <= 1'b0;
         rdata_reg  <= '0;
      end else begin
         ovr_reg    <= ovr_next;
         ferr_reg   <= ferr_next;
         irq_en_reg <= irq_en_next;
         ack_reg    <= req;
         rdata_reg  <= rdata_next;
      end
   end

   assign wb_ack_o  = ack_reg;
   assign wb_data_o = rdata_reg;
   assign rx_irq_o  = irq_en_reg & (~empty | ovr_reg | ferr_reg);

endmodule

// File: tb/tb_wb_uart_rx.sv
// Directed bench for wb_uart_rx: a byte-queue scoreboard predicts every
// DATA/STATUS read from the frames driven onto the serial line.
module tb_wb_uart_rx;
   localparam int CPB   = 16;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] wb_addr = '0;
   logic [31:0] wb_wdata = '0;
   logic [3:0]  wb_sel = 4'hF;
   logic        wb_we = 1'b0;
   logic        wb_cyc = 1'b0;
   logic        wb_stb = 1'b0;
   logic        wb_ack;
   logic [31:0] wb_rdata;
   logic        uart_rx = 1'b1;
   logic        rx_irq;

   int tests = 0;
   int failures = 0;

   logic [7:0] model_q[$];
   bit         model_ovr = 1'b0;
   bit         model_ferr = 1'b0;
   logic [31:0] rd;

   always #5 clk = ~clk;

   wb_uart_rx #(
      .WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .wb_addr_i(wb_addr), .wb_data_i(wb_wdata), .wb_sel_i(wb_sel),
      .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
      .wb_ack_o(wb_ack), .wb_data_o(wb_rdata),
      .uart_rx_i(uart_rx), .rx_irq_o(rx_irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s = '0;
      s[0]    = (model_q.size() != 0);
      s[1]    = (model_q.size() == DEPTH);
      s[2]    = model_ovr;
      s[3]    = model_ferr;
      s[11:8] = 4'(model_q.size());
      return s;
   endfunction

   function automatic logic [31:0] exp_data();
      logic [31:0] d;
      d = '0;
      if (model_q.size() != 0) begin
         d[31]  = 1'b1;
         d[7:0] = model_q.pop_front();
      end
      return d;
   endfunction

   task automatic wb_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          output logic [31:0] rdata);
      int n;
      wb_addr  = addr;
      wb_we    = we;
      wb_wdata = wdata;
      wb_cyc   = 1'b1;
      wb_stb   = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!wb_ack && n < 20);
      check("ack_seen", {31'b0, wb_ack}, 32'd1);
      rdata  = wb_rdata;
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
      @(negedge clk);
      check("ack_single", {31'b0, wb_ack}, 32'd0);
   endtask

   task automatic read_check(input logic [31:0] addr, input string tag);
      logic [31:0] exp;
      exp = (addr == 32'h0) ? exp_data() : exp_status();
      wb_xfer(addr, 1'b0, 32'h0, rd);
      check(tag, rd, exp);
      $display("[TB] read  0x%0h -> 0x%08h (expected 0x%08h) %s", addr, rd, exp, tag);
   endtask

   task automatic send_bits(input logic [7:0] b);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      send_bits(b);
      uart_rx = stop;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (CPB) @(negedge clk);
      if (stop) begin
         if (model_q.size() < DEPTH) model_q.push_back(b);
         else model_ovr = 1'b1;
      end else begin
         model_ferr = 1'b1;
      end
      $display("[TB] frame 0x%02h stop=%0d sent", b, stop);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("rst_ack", {31'b0, wb_ack}, 32'd0);
      check("rst_data", wb_rdata, 32'd0);
      check("rst_irq", {31'b0, rx_irq}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      read_check(32'h4, "status_after_reset");

      // Single valid frame
      send_frame(8'hA5, 1'b1);
      read_check(32'h4, "a5_status");
      read_check(32'h0, "a5_data");
      read_check(32'h4, "a5_status_empty");

      // Nine frames into an eight-deep FIFO
      for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1);
      read_check(32'h4, "ovr_status");
      for (int i = 0; i < 9; i++) read_check(32'h0, $sformatf("drain_%0d", i));
      wb_xfer(32'h4, 1'b1, 32'h4, rd);
      model_ovr = 1'b0;
      read_check(32'h4, "ovr_cleared");

      // Framing error
      send_frame(8'h3C, 1'b0);
      read_check(32'h4, "ferr_status");
      wb_xfer(32'h4, 1'b1, 32'h8, rd);
      model_ferr = 1'b0;
      read_check(32'h4, "ferr_cleared");

      // Short low glitch must not start a frame
      uart_rx = 1'b0;
      repeat (4) @(negedge clk);
      uart_rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      read_check(32'h4, "glitch_status");

      // Interrupt enable and timing
      wb_xfer(32'h8, 1'b1, 32'h1, rd);
      wb_xfer(32'h8, 1'b0, 32'h0, rd);
      check("ctrl_readback", rd, 32'h1);
      check("irq_idle", {31'b0, rx_irq}, 32'd0);
      send_bits(8'h55);
      uart_rx = 1'b1;
      n = 0;
      while (!rx_irq && n < CPB) begin
         @(negedge clk);
         n++;
      end
      check("irq_rise", {31'b0, rx_irq}, 32'd1);
      check("irq_rise_time", {31'b0, (n >= CPB / 2) && (n <= CPB / 2 + 6)}, 32'd1);
      repeat (2 * CPB) @(negedge clk);
      model_q.push_back(8'h55);
      read_check(32'h0, "irq_data");
      check("irq_fall", {31'b0, rx_irq}, 32'd0);

      // Reset in the middle of bit 4, with a byte already queued
      send_frame(8'h77, 1'b1);
      check("irq_pending", {31'b0, rx_irq}, 32'd1);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         uart_rx = i[0] ? 1'b1 : 1'b0;
         repeat (CPB) @(negedge clk);
      end
      uart_rx = 1'b1;
      repeat (CPB / 2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_ack", {31'b0, wb_ack}, 32'd0);
      check("midrst_data", wb_rdata, 32'd0);
      check("midrst_irq", {31'b0, rx_irq}, 32'd0);
      model_q.delete();
      model_ovr = 1'b0;
      model_ferr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4 * CPB) @(negedge clk);
      read_check(32'h4, "midrst_status");
      wb_xfer(32'h8, 1'b0, 32'h0, rd);
      check("midrst_ctrl", rd, 32'h0);
      send_frame(8'h12, 1'b1);
      read_check(32'h4, "post_rst_status");
      read_check(32'h0, "post_rst_data");
      wb_xfer(32'hC, 1'b0, 32'h0, rd);
      check("addr_c", rd, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end
endmodule
